caliptra_prim_skid_buf: RTL and testbench
=========================================

# caliptra_prim_skid_buf

Two-entry valid/ready register slice (skid buffer) for the consumer side of registered datapaths. It accepts a word per cycle from an upstream producer and presents it, registered, to a downstream consumer. Every output (`valid_o`, `data_o`, `ready_o`) comes straight from a flop, so no combinational path crosses the block in either direction. It sits between prim flop stages wherever a registered stage must honour downstream backpressure at full throughput.

## Interface
- `Width`, 32: data word width in bits, ≥1.
- `ResetValue`, '0: value of `data_o` and of the skid register on reset and after flush.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low.
- `flush_i`  in  1  synchronous clear of buffered contents.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  upstream may transfer; registered.
- `data_i`  in  Width  upstream word.
- `valid_o`  out  1  downstream word valid; registered.
- `ready_i`  in  1  downstream accepts.
- `data_o`  out  Width  downstream word; registered (main register).
- `count_o`  out  2  occupancy, 0..2; registered.

## Operation
- Input fire: `in_fire = valid_i & ready_o`. Output fire: `out_fire = valid_o & ready_i`.
- Storage: a main register drives `data_o`, and a skid register holds a second word. States are EMPTY (count 0), ONE (count 1, main valid) and FULL (count 2, main and skid valid).
- EMPTY:
  - in_fire → ONE; main ← `data_i`.
- ONE:
  - in_fire & out_fire → ONE; main ← `data_i`.
  - in_fire & !out_fire → FULL; skid ← `data_i`.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- FULL: `ready_o` = 0, so in_fire cannot occur.
  - out_fire → ONE; main ← skid.
  - Otherwise hold.
- Derived outputs:
  - `valid_o` = (state ≠ EMPTY).
  - `count_o` = state encoding 0/1/2.
  - Next `ready_o` = (next state ≠ FULL) & `rst_ni`.
- Ordering: words leave in exactly the order accepted; none is dropped or duplicated unless a flush occurs.
- Flush: when `flush_i`=1 at an edge, next state is EMPTY, main and skid ← `ResetValue`, and `ready_o` ← 1.
  - An out_fire in the flush cycle counts as delivered.
  - An in_fire in the flush cycle is accepted by the handshake and then discarded.
- Reset has priority over flush.
- Register updates: `data_o` changes only on a main load, flush or reset; it holds while `valid_o` & !`ready_i`. The skid register loads only on the ONE → FULL transition.

## Timing
- Reset (`rst_ni`=0 at an edge) sets: state EMPTY, `valid_o` 0, `count_o` 0, `data_o` `ResetValue`, skid `ResetValue`, `ready_o` 0.
- First edge with `rst_ni`=1: `ready_o` → 1. The earliest in_fire is therefore the second cycle after reset release.
- Latency: a word accepted at edge N appears on `data_o` with `valid_o`=1 in cycle N+1 if the buffer was EMPTY or ONE-with-out_fire. Otherwise it appears after all older words drain.
- Throughput: 1 word/cycle sustained while `ready_i`=1.
- Backpressure:
  - With `ready_i` held 0, the buffer absorbs exactly 2 words.
  - `ready_o` falls in the cycle after the second accept.
  - `ready_o` rises in the cycle after the first out_fire from FULL.
- Reset mid-operation: contents are lost and all outputs return to reset values at that edge, regardless of handshakes in progress.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles with `valid_i`=1 → `valid_o`=0, `ready_o`=0, `count_o`=0, `data_o`=`ResetValue` throughout. `ready_o`=1 one cycle after release.
- Streaming: `ready_i`=1, send 0x01..0x10 back-to-back → `data_o` shows 0x01..0x10 on consecutive cycles, one cycle behind the input, with `ready_o` constantly 1.
- Backpressure fill: `ready_i`=0, send 0xA, 0xB, 0xC → 0xA and 0xB accepted, `count_o`=2, `ready_o`=0 while 0xC is held. Then `ready_i`=1 → output order 0xA, 0xB, 0xC with no loss.
- Random stall: random `valid_i`/`ready_i` at 50% over 10k cycles → scoreboard shows in-order, lossless delivery, `count_o` never exceeds 2, and `data_o` stable while `valid_o` & !`ready_i`.
- Flush in FULL: buffer holds 0x5, 0x6; assert `flush_i` with `ready_i`=1 → 0x5 counted as delivered, 0x6 discarded. Next cycle: `count_o`=0, `valid_o`=0, `ready_o`=1, `data_o`=`ResetValue`.
- Reset mid-stream: assert `rst_ni`=0 while FULL → state EMPTY and `ready_o`=0 at that edge. Post-release traffic shows no stale words.

Source files
------------

// File: rtl/caliptra_prim_skid_buf.sv
// caliptra_prim_skid_buf: two-entry valid/ready register slice with fully registered outputs
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   flush_i          synchronous clear of buffered words
//   valid_i, data_i  upstream word, ready_o tells upstream it may transfer
//   valid_o, data_o  downstream word (main register), ready_i from downstream
//   count_o          occupancy 0..2
module caliptra_prim_skid_buf #(
   parameter int unsigned           Width      = 32,
   parameter logic [Width-1:0]      ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic [1:0]       count_o
);
   localparam logic [1:0] Empty = 2'd0;
   localparam logic [1:0] One   = 2'd1;
   localparam logic [1:0] Full  = 2'd2;
   logic [1:0]       state_q, state_d;
   logic [Width-1:0] main_q, main_d, skid_q, skid_d;
   logic             valid_q, ready_q;
   logic             in_fire, out_fire;
   assign in_fire  = valid_i & ready_q;
   assign out_fire = valid_q & ready_i;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         Empty: if (in_fire) begin
            state_d = One;
            main_d  = data_i;
         end
         One: begin
            if (in_fire && out_fire) main_d = data_i;
            else if (in_fire) begin
               state_d = Full;
               skid_d  = data_i;
            end
            else if (out_fire) state_d = Empty;
         end
         Full: if (out_fire) begin
            state_d = One;
            main_d  = skid_q;
         end
         default: state_d = Empty;
      endcase
      // A word accepted in the flush cycle is taken by the handshake and then dropped here
      if (flush_i) begin
         state_d = Empty;
         main_d  = ResetValue;
         skid_d  = ResetValue;
      end
   end
   // valid and ready are kept in their own flops so every output leaves a register directly
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= Empty;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         main_q  <= ResetValue;
         skid_q  <= ResetValue;
      end else begin
         state_q <= state_d;
         valid_q <= state_d != Empty;
         ready_q <= state_d != Full;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
   assign valid_o = valid_q;
   assign ready_o = ready_q;
   assign data_o  = main_q;
   assign count_o = state_q;
endmodule

// File: tb/tb_caliptra_prim_skid_buf.sv
// tb_caliptra_prim_skid_buf: vector table, directed corner cases and random traffic against a queue model
module tb_caliptra_prim_skid_buf;
   localparam int W = 16;
   localparam logic [W-1:0] RV = 16'hA5A5;
   logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
   logic [W-1:0] data_i = '0;
   logic ready_o, valid_o;
   logic [W-1:0] data_o;
   logic [1:0] count_o;
   int total = 0, bad = 0;
   logic [W-1:0] q[$];
   logic ready_m = 1'b0;
   logic [W-1:0] data_m = RV;
   always #5 clk_i = ~clk_i;
   caliptra_prim_skid_buf #(.Width(W), .ResetValue(RV)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .count_o(count_o)
   );
   typedef struct {
      bit r, f, v, rd;
      logic [W-1:0] d;
      bit ev, er;
      logic [1:0] ec;
      logic [W-1:0] ed;
   } vec_t;
   vec_t tbl[10];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference: a FIFO of accepted words, capacity two, ready one cycle behind occupancy
   task automatic step(input bit r, input bit f, input bit v, input bit rd, input logic [W-1:0] d);
      bit inf, outf;
      rst_ni = r; flush_i = f; valid_i = v; ready_i = rd; data_i = d;
      @(posedge clk_i); #1;
      if (!r) begin
         q.delete();
         ready_m = 1'b0;
         data_m = RV;
      end else begin
         inf = v && ready_m;
         outf = q.size() > 0 && rd;
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(d);
         if (f) begin
            q.delete();
            data_m = RV;
         end else if (q.size() > 0) data_m = q[0];
         ready_m = q.size() < 2;
      end
      chk("m_valid", {31'd0, valid_o}, {31'd0, q.size() > 0});
      chk("m_ready", {31'd0, ready_o}, {31'd0, ready_m});
      chk("m_count", {30'd0, count_o}, q.size());
      chk("m_data", {16'd0, data_o}, {16'd0, data_m});
   endtask
   initial begin
      tbl[0] = '{0,0,1,0,16'h0011, 0,0,2'd0,RV};
      tbl[1] = '{0,0,1,0,16'h0011, 0,0,2'd0,RV};
      tbl[2] = '{0,0,1,0,16'h0011, 0,0,2'd0,RV};
      tbl[3] = '{1,0,0,0,16'h0000, 0,1,2'd0,RV};
      tbl[4] = '{1,0,1,0,16'h000A, 1,1,2'd1,16'h000A};
      tbl[5] = '{1,0,1,0,16'h000B, 1,0,2'd2,16'h000A};
      tbl[6] = '{1,0,1,0,16'h000C, 1,0,2'd2,16'h000A};
      tbl[7] = '{1,0,1,1,16'h000C, 1,1,2'd1,16'h000B};
      tbl[8] = '{1,0,1,1,16'h000C, 1,1,2'd1,16'h000C};
      tbl[9] = '{1,0,0,1,16'h0000, 0,1,2'd0,16'h000C};
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].rd, tbl[i].d);
         chk($sformatf("t%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].ev});
         chk($sformatf("t%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].er});
         chk($sformatf("t%0d_count", i), {30'd0, count_o}, {30'd0, tbl[i].ec});
         chk($sformatf("t%0d_data", i), {16'd0, data_o}, {16'd0, tbl[i].ed});
      end
      for (int i = 1; i <= 16; i++) begin
         step(1, 0, 1, 1, W'(i));
         chk("stream_data", {16'd0, data_o}, i);
         chk("stream_ready", {31'd0, ready_o}, 32'd1);
      end
      step(1, 0, 0, 1, '0);
      chk("stream_drain_valid", {31'd0, valid_o}, 32'd0);
      step(1, 0, 1, 0, 16'h0005);
      step(1, 0, 1, 0, 16'h0006);
      chk("flush_pre_count", {30'd0, count_o}, 32'd2);
      step(1, 1, 0, 1, '0);
      chk("flush_count", {30'd0, count_o}, 32'd0);
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      chk("flush_ready", {31'd0, ready_o}, 32'd1);
      chk("flush_data", {16'd0, data_o}, {16'd0, RV});
      step(1, 0, 1, 0, 16'h0031);
      step(1, 1, 1, 1, 16'h0032);
      chk("flush_in_drop", {30'd0, count_o}, 32'd0);
      step(1, 0, 1, 0, 16'h0007);
      step(1, 0, 1, 0, 16'h0008);
      step(0, 0, 1, 1, 16'h0009);
      chk("rst_mid_count", {30'd0, count_o}, 32'd0);
      chk("rst_mid_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_mid_data", {16'd0, data_o}, {16'd0, RV});
      step(1, 0, 1, 1, 16'h0009);
      chk("rst_rel_valid", {31'd0, valid_o}, 32'd0);
      step(1, 0, 1, 1, 16'h0021);
      chk("rst_post_data", {16'd0, data_o}, 32'h21);
      step(1, 0, 0, 1, '0);
      for (int i = 0; i < 10000; i++)
         step(1, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
